// File: rtl/bus_drive_arbiter_pkg.sv
//==============================================================
// bus_arb_pkg : shared state encodings and defaults for the bus drive arbiter
// Revision 1.0
//==============================================================
`default_nettype none

package bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_TURNAROUND = 1;
   localparam int DEF_MAX_HOLD   = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_drive_arbiter_if.sv
//==============================================================
// bus_drive_arbiter_if : request/enable bundle between bus sources and arbiter
// Revision 1.0
//==============================================================
`default_nettype none

interface bus_drive_arbiter_if
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] drive_en;
   logic [ID_W-1:0]    grant_id;
   logic               grant_valid;
   logic               bus_turn;
   logic               preempt;

   modport master (
      input  req,
      output drive_en, grant_id, grant_valid, bus_turn, preempt
   );

   modport slave (
      output req,
      input  drive_en, grant_id, grant_valid, bus_turn, preempt
   );

endinterface

`default_nettype wire

// File: rtl/bus_drive_arbiter_rr_pick.sv
//==============================================================
// rr_pick : first set request scanning upward from rr_ptr, wrapping
// Revision 1.0
//==============================================================
`default_nettype none

module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    winner,
   output logic               any_req
);

   logic [ID_W-1:0] sel;

   // Scan offsets high to low so the smallest offset from rr_ptr wins last.
   always_comb begin
      winner  = '0;
      sel     = '0;
      any_req = |req;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         sel = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (req[sel]) winner = sel;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_drive_arbiter.sv
//==============================================================
// bus_drive_arbiter : round-robin tristate enable sequencer with turnaround and hold limit
// Revision 1.0
//==============================================================
`default_nettype none

module bus_drive_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int TURNAROUND = DEF_TURNAROUND,
   parameter int MAX_HOLD   = DEF_MAX_HOLD,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   bus_drive_arbiter_if.master bus
);

   localparam int HOLD_W = cnt_w(MAX_HOLD);
   localparam int TURN_W = cnt_w(TURNAROUND);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [TURN_W-1:0]   turn_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [NUM_REQ-1:0]  drive_en;
   logic [ID_W-1:0]     grant_id;
   logic                grant_valid;
   logic                bus_turn;
   logic                preempt;

   logic [ID_W-1:0]     winner;
   logic                any_req;
   logic [ID_W-1:0]     next_ptr;
   logic [NUM_REQ-1:0]  grant_vec;
   logic                owner_req;
   logic                others_req;
   logic                forced;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req     (bus.req),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign next_ptr   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
   assign grant_vec  = NUM_REQ'(1) << winner;
   // drive_en is one-hot while owning, so it doubles as the owner mask.
   assign owner_req  = |(bus.req & drive_en);
   assign others_req = |(bus.req & ~drive_en);
   assign forced     = (hold_cnt == HOLD_LAST) && others_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         turn_cnt    <= '0;
         hold_cnt    <= '0;
         drive_en    <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         bus_turn    <= 1'b0;
         preempt     <= 1'b0;
      end else begin
         preempt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state       <= ST_OWN;
                  drive_en    <= grant_vec;
                  grant_id    <= winner;
                  grant_valid <= 1'b1;
                  hold_cnt    <= '0;
                  rr_ptr      <= next_ptr;
               end
            end
            ST_OWN: begin
               if (!owner_req || forced) begin
                  state       <= ST_TURN;
                  drive_en    <= '0;
                  grant_valid <= 1'b0;
                  bus_turn    <= 1'b1;
                  turn_cnt    <= TURN_LAST;
                  // A release the owner asked for is not a preemption.
                  preempt     <= owner_req;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            ST_TURN: begin
               if (turn_cnt == '0) begin
                  bus_turn <= 1'b0;
                  if (any_req) begin
                     state       <= ST_OWN;
                     drive_en    <= grant_vec;
                     grant_id    <= winner;
                     grant_valid <= 1'b1;
                     hold_cnt    <= '0;
                     rr_ptr      <= next_ptr;
                  end else begin
                     state    <= ST_IDLE;
                     grant_id <= '0;
                  end
               end else begin
                  turn_cnt <= turn_cnt - TURN_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.drive_en    = drive_en;
   assign bus.grant_id    = grant_id;
   assign bus.grant_valid = grant_valid;
   assign bus.bus_turn    = bus_turn;
   assign bus.preempt     = preempt;

endmodule

`default_nettype wire
